acc_regfile: RTL and testbench
==============================

// Module: acc_regfile
// PURPOSE
//  Accumulator register file; responder side of the GEMM core's acc port (addr/wdata out, rdata in).
//  Single-port synchronous RAM of ACC_DEPTH words.
//  - GEMM traffic is never stalled.
//  - Idle cycles are shared between a DMA load port (valid/ready) and a range-clear sweep engine.
//  Sits between the load module and the GEMM core inside the compute stage.
// PARAMETERS
//  ACC_DEPTH  8192  number of accumulator words
//  ADDR_W     13    address width, $clog2(ACC_DEPTH)
//  DATA_W     32    accumulator word width
// PORTS
//  ap_clk         in   1       clock; all logic rising-edge
//  ap_rst_n       in   1       asynchronous active-low reset
//  gemm_acc_en    in   1       GEMM access this cycle
//  gemm_acc_we    in   1       1=write, 0=read (qualified by en)
//  gemm_acc_addr  in   ADDR_W  GEMM address
//  gemm_acc_wdata in   DATA_W  GEMM write data
//  gemm_acc_rdata out  DATA_W  GEMM read data
//  gemm_acc_rvld  out  1       rdata valid pulse
//  ld_valid       in   1       load-port word offered
//  ld_ready       out  1       load-port word accepted this cycle
//  ld_addr        in   ADDR_W  load address
//  ld_data        in   DATA_W  load data
//  clr_start      in   1       start clear sweep (pulse)
//  clr_base       in   ADDR_W  first address to clear
//  clr_count      in   ADDR_W+1  words to clear; 0..ACC_DEPTH
//  clr_busy       out  1       sweep in progress
//  clr_done       out  1       one-cycle pulse at sweep end
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> IDLE; RAM contents untouched and undefined after power-up.
//  Port priority per cycle, one RAM access max: GEMM > clear sweep > load port.
//  GEMM read: en=1, we=0 at cycle N -> rdata/rvld at N+1.
//    rdata holds its last value; rvld is 1 for one cycle only.
//  GEMM write: committed at the edge ending cycle N; a GEMM read of the same address at N+1 returns new data.
//  ld_ready = ld_valid & ~gemm_acc_en & (state==IDLE); combinational.
//    Write occurs the same cycle. ld_valid without ld_ready: hold addr/data.
//  FSM IDLE -> CLEAR on clr_start (count>0).
//    Captures ptr=clr_base, rem=clr_count, clr_busy=1 next cycle.
//  CLEAR: each cycle with gemm_acc_en=0, writes 0 to ptr; ptr++ (wraps mod ACC_DEPTH); rem--.
//    Cycles with gemm_acc_en=1 stall the sweep with no write.
//  CLEAR -> IDLE when rem reaches 0: clr_busy falls, clr_done pulses the same cycle.
//  clr_start with count=0: no writes, no busy; clr_done pulses next cycle.
//  clr_start while busy: ignored. clr_count > ACC_DEPTH: saturates to ACC_DEPTH.
//  Reset mid-sweep: FSM aborts to IDLE, no done pulse; partially cleared range stays as-is.
// CONFIGURATION
//  ACC_PARITY_EN defined:
//    RAM stores DATA_W+1 bits; even parity generated on every write (incl. clear).
//    Checked on GEMM read; extra output par_err (1 bit) pulses with rvld on mismatch.
//  ACC_PARITY_EN undefined: DATA_W-bit RAM, no par_err port, no parity logic.
// STRUCTURE
//  Shared package vta_acc_pkg: ADDR_W/DATA_W constants, acc_state_t enum {IDLE, CLEAR}.
//  One sub-module acc_ram: inferred single-port sync RAM, 1-cycle read, width from macro.
//  Top holds arbiter, clear FSM, rvld/rdata register and parity logic.
// TESTING
//  Load 0x11..0x18 to addr 0..7 with valid held, GEMM idle -> 8 ready pulses; GEMM reads of 0..7 return 0x11..0x18 at N+1.
//  GEMM writes 0xDEAD_BEEF @5, reads @5 next cycle -> rdata=0xDEADBEEF, rvld=1 one cycle later.
//  clr base=0x1FFE count=4 -> writes 0 to 0x1FFE,0x1FFF,0x0000,0x0001 (wrap); done after 4 free cycles.
//  Sweep with GEMM en asserted 3 cycles mid-way plus ld_valid -> sweep stalls 3, ld_ready=0 throughout, done delayed 3.
//  clr count=0 -> clr_busy stays 0, clr_done pulses next cycle; clr_start while busy ignored.
//  ACC_PARITY_EN: force-flip stored bit via backdoor @9, GEMM read @9 -> par_err=1 with rvld.
//    ap_rst_n low mid-sweep -> busy=0, no done.

Source files
------------

// File: rtl/vta_acc_pkg.sv
// vta_acc_pkg: shared constants, clear-FSM state type and count saturation helper
// for the accumulator register file.
`default_nettype none

package vta_acc_pkg;

    localparam int ACC_DEPTH = 8192;
    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = ADDR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(ACC_DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } acc_state_t;

    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] cnt);
        return (cnt > DEPTH_CNT) ? DEPTH_CNT : cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/acc_ram.sv
// acc_ram: inferred single-port synchronous RAM, one-cycle read latency.
// Read register resets to zero and holds between reads; array contents never reset.
`default_nettype none

module acc_ram #(
    parameter int DEPTH = 8192,
    parameter int AW    = 13,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we)
            mem[addr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (en && !we)
            rdata <= mem[addr];
    end

endmodule

`default_nettype wire

// File: rtl/acc_regfile.sv
// acc_regfile: accumulator RAM with GEMM > clear-sweep > load-port arbitration.
// Optional macro ACC_PARITY_EN adds a stored even-parity bit and the par_err output.
`default_nettype none

module acc_regfile
    import vta_acc_pkg::*;
(
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              gemm_acc_en,
    input  logic              gemm_acc_we,
    input  logic [ADDR_W-1:0] gemm_acc_addr,
    input  logic [DATA_W-1:0] gemm_acc_wdata,
    output logic [DATA_W-1:0] gemm_acc_rdata,
    output logic              gemm_acc_rvld,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              clr_start,
    input  logic [ADDR_W-1:0] clr_base,
    input  logic [ADDR_W:0]   clr_count,
    output logic              clr_busy,
    output logic              clr_done
`ifdef ACC_PARITY_EN
    ,
    output logic              par_err
`endif
);

`ifdef ACC_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif

    acc_state_t        state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  start_cnt;
    logic              clr_wr;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [RAM_W-1:0]  ram_wfull;
    logic [RAM_W-1:0]  ram_rdata;

    assign start_cnt = sat_count(clr_count);
    assign clr_wr    = (state == CLEAR) && !gemm_acc_en;
    assign ld_ready  = ld_valid && !gemm_acc_en && (state == IDLE);
    assign clr_busy  = (state == CLEAR);

    // One RAM access per cycle: GEMM wins, then the sweep, then the load port.
    always_comb begin
        ram_en    = gemm_acc_en || clr_wr || ld_ready;
        ram_we    = 1'b1;
        ram_addr  = ld_addr;
        ram_wdata = ld_data;
        if (gemm_acc_en) begin
            ram_we    = gemm_acc_we;
            ram_addr  = gemm_acc_addr;
            ram_wdata = gemm_acc_wdata;
        end else if (clr_wr) begin
            ram_addr  = ptr;
            ram_wdata = '0;
        end
    end

`ifdef ACC_PARITY_EN
    assign ram_wfull      = {^ram_wdata, ram_wdata};
    assign gemm_acc_rdata = ram_rdata[DATA_W-1:0];
    assign par_err        = gemm_acc_rvld && (^ram_rdata);
`else
    assign ram_wfull      = ram_wdata;
    assign gemm_acc_rdata = ram_rdata;
`endif

    acc_ram #(
        .DEPTH (ACC_DEPTH),
        .AW    (ADDR_W),
        .WIDTH (RAM_W)
    ) u_ram (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wfull),
        .rdata (ram_rdata)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_start && (start_cnt != '0)) state_nxt = CLEAR;
            CLEAR:   if (clr_wr && (rem == CNT_W'(1)))   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A zero-length request still reports completion, one cycle after the start.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr           <= '0;
            rem           <= '0;
            clr_done      <= 1'b0;
            gemm_acc_rvld <= 1'b0;
        end else begin
            clr_done      <= 1'b0;
            gemm_acc_rvld <= gemm_acc_en && !gemm_acc_we;
            if (state == IDLE && clr_start) begin
                ptr <= clr_base;
                rem <= start_cnt;
                if (start_cnt == '0)
                    clr_done <= 1'b1;
            end else if (clr_wr) begin
                ptr <= ptr + 1'b1;
                rem <= rem - 1'b1;
                if (rem == CNT_W'(1))
                    clr_done <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_acc_regfile.sv
// tb_acc_regfile: directed self-checking bench for acc_regfile.
`default_nettype none

module tb_acc_regfile;
    import vta_acc_pkg::*;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic              gemm_acc_en = 1'b0;
    logic              gemm_acc_we = 1'b0;
    logic [ADDR_W-1:0] gemm_acc_addr = '0;
    logic [DATA_W-1:0] gemm_acc_wdata = '0;
    logic [DATA_W-1:0] gemm_acc_rdata;
    logic              gemm_acc_rvld;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;
    logic              clr_start = 1'b0;
    logic [ADDR_W-1:0] clr_base = '0;
    logic [ADDR_W:0]   clr_count = '0;
    logic              clr_busy;
    logic              clr_done;
`ifdef ACC_PARITY_EN
    logic              par_err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    acc_regfile dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .gemm_acc_en    (gemm_acc_en),
        .gemm_acc_we    (gemm_acc_we),
        .gemm_acc_addr  (gemm_acc_addr),
        .gemm_acc_wdata (gemm_acc_wdata),
        .gemm_acc_rdata (gemm_acc_rdata),
        .gemm_acc_rvld  (gemm_acc_rvld),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .clr_start      (clr_start),
        .clr_base       (clr_base),
        .clr_count      (clr_count),
        .clr_busy       (clr_busy),
        .clr_done       (clr_done)
`ifdef ACC_PARITY_EN
        ,
        .par_err        (par_err)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic ld_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic gemm_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        gemm_acc_en    = 1'b1;
        gemm_acc_we    = 1'b1;
        gemm_acc_addr  = a;
        gemm_acc_wdata = d;
        tick();
        gemm_acc_en = 1'b0;
        gemm_acc_we = 1'b0;
    endtask

    task automatic gemm_read(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        gemm_acc_en   = 1'b1;
        gemm_acc_we   = 1'b0;
        gemm_acc_addr = a;
        tick();
        gemm_acc_en = 1'b0;
        chk({tag, "_rvld"}, gemm_acc_rvld, 1);
        chk(tag, gemm_acc_rdata, exp);
`ifdef ACC_PARITY_EN
        chk({tag, "_par"}, par_err, 0);
`endif
    endtask

    task automatic clr_go(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
        clr_base  = b;
        clr_count = c;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 0;
        while (!clr_done && cyc < max_cyc) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int pulses;
        int bad;
        int k;

        #2;
        chk("rst_rdata", gemm_acc_rdata, 0);
        chk("rst_rvld",  gemm_acc_rvld, 0);
        chk("rst_ready", ld_ready, 0);
        chk("rst_busy",  clr_busy, 0);
        chk("rst_done",  clr_done, 0);
        #20 ap_rst_n = 1'b1;
        tick();

        // Load 0x11..0x18 with valid held
        pulses = 0;
        ld_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ld_addr = ADDR_W'(i);
            ld_data = 32'h11 + i;
            #1;
            if (ld_ready) pulses++;
            tick();
        end
        ld_valid = 1'b0;
        chk("ld_pulses", pulses, 8);
        for (int i = 0; i < 8; i++)
            gemm_read($sformatf("rd%0d", i), ADDR_W'(i), 32'h11 + i);

        // Load port blocked by GEMM
        ld_valid = 1'b1; ld_addr = 13'h7; ld_data = 32'hBAD;
        gemm_acc_en = 1'b1; gemm_acc_we = 1'b0; gemm_acc_addr = '0;
        #1 chk("ld_blocked", ld_ready, 0);
        tick();
        ld_valid = 1'b0; gemm_acc_en = 1'b0;
        tick();
        gemm_read("rd7_kept", 13'h7, 32'h18);

        // GEMM write then read-after-write
        gemm_write(13'd5, 32'hDEAD_BEEF);
        gemm_read("raw5", 13'd5, 32'hDEAD_BEEF);
        tick();
        chk("rvld_pulse", gemm_acc_rvld, 0);
        chk("rdata_hold", gemm_acc_rdata, 32'hDEAD_BEEF);

        // Wrapping clear sweep
        ld_write(13'h1FFE, 32'hA1);
        ld_write(13'h1FFF, 32'hA2);
        clr_go(13'h1FFE, 14'd4);
        chk("wrap_busy", clr_busy, 1);
        wait_done(20, cyc);
        chk("wrap_cycles", cyc, 4);
        chk("wrap_busy_end", clr_busy, 0);
        tick();
        chk("wrap_done_pulse", clr_done, 0);
        gemm_read("wrap_1ffe", 13'h1FFE, 0);
        gemm_read("wrap_1fff", 13'h1FFF, 0);
        gemm_read("wrap_0", 13'h0, 0);
        gemm_read("wrap_1", 13'h1, 0);
        gemm_read("wrap_2", 13'h2, 32'h13);

        // Sweep stalled by GEMM for 3 cycles with a load offered throughout
        for (int i = 0; i < 5; i++)
            ld_write(ADDR_W'(13'h10 + i), 32'h50 + i);
        ld_write(13'h20, 32'h66);
        clr_go(13'h10, 14'd4);
        ld_valid = 1'b1; ld_addr = 13'h20; ld_data = 32'h77;
        bad = 0;
        k = 0;
        while (k < 20) begin
            k++;
            gemm_acc_en   = (k >= 2 && k <= 4);
            gemm_acc_we   = 1'b0;
            gemm_acc_addr = 13'h0;
            #1;
            if (ld_ready) bad++;
            tick();
            if (clr_done) break;
        end
        ld_valid = 1'b0;
        gemm_acc_en = 1'b0;
        chk("stall_ld_ready", bad, 0);
        chk("stall_cycles", k, 7);
        for (int i = 0; i < 4; i++)
            gemm_read($sformatf("stall_clr%0d", i), ADDR_W'(13'h10 + i), 0);
        gemm_read("stall_14", 13'h14, 32'h54);
        gemm_read("stall_20", 13'h20, 32'h66);

        // Zero-length clear
        clr_go(13'h30, 14'd0);
        chk("zero_busy", clr_busy, 0);
        chk("zero_done", clr_done, 1);
        tick();
        chk("zero_done_end", clr_done, 0);

        // Start while busy is ignored
        ld_write(13'h32, 32'h32);
        ld_write(13'h40, 32'h99);
        clr_go(13'h30, 14'd3);
        clr_base = 13'h40; clr_count = 14'd5; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        wait_done(20, cyc);
        chk("ign_cycles", cyc, 2);
        gemm_read("ign_32", 13'h32, 0);
        gemm_read("ign_40", 13'h40, 32'h99);

        // Reset mid-sweep
        for (int i = 0; i < 4; i++)
            ld_write(ADDR_W'(13'h60 + i), 32'hF0 + i);
        clr_go(13'h60, 14'd10);
        tick();
        tick();
        ap_rst_n = 1'b0;
        #1;
        chk("rstmid_busy", clr_busy, 0);
        chk("rstmid_done", clr_done, 0);
        #2 ap_rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (clr_done || clr_busy) bad++;
        end
        chk("rstmid_quiet", bad, 0);
        gemm_read("rstmid_61", 13'h61, 0);
        gemm_read("rstmid_62", 13'h62, 32'hF2);

        // Oversized count saturates to full depth
        clr_go(13'h0, 14'h3FFF);
        wait_done(9000, cyc);
        chk("sat_cycles", cyc, ACC_DEPTH);
        gemm_read("sat_40", 13'h40, 0);

`ifdef ACC_PARITY_EN
        gemm_write(13'd9, 32'h1234_5678);
        dut.u_ram.mem[9][0] = ~dut.u_ram.mem[9][0];
        gemm_acc_en = 1'b1; gemm_acc_we = 1'b0; gemm_acc_addr = 13'd9;
        tick();
        gemm_acc_en = 1'b0;
        chk("par_rvld", gemm_acc_rvld, 1);
        chk("par_err", par_err, 1);
        tick();
        chk("par_err_pulse", par_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
